// File: rtl/systemizer_pkg.sv
// Shared types and geometry helpers for the systemizer feeder.
package systemizer_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_LOADED,
    S_RUN,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'b00,
    STAT_SUCCESS = 2'b01,
    STAT_FAIL    = 2'b10,
    STAT_TIMEOUT = 2'b11
  } status_e;

  function automatic int calc_wpr(input int k, input int block);
    return (k + block - 1) / block;
  endfunction

  function automatic int calc_depth(input int l, input int k, input int block);
    return l * calc_wpr(k, block);
  endfunction

  function automatic int calc_aw(input int l, input int k, input int block);
    int d;
    d = calc_depth(l, k, block);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/systemizer_feeder_if.sv
// Bundle of load stream, systemizer ports, drain stream and status for the feeder.
interface systemizer_feeder_if #(
  parameter int BLOCK = 4,
  parameter int AW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [BLOCK-1:0] in_data;
  logic             go;
  logic             sys_start;
  logic             sys_done;
  logic             sys_fail;
  logic             sys_success;
  logic             sys_rd_en;
  logic [AW-1:0]    sys_rd_addr;
  logic [BLOCK-1:0] sys_rd_data;
  logic             sys_wr_en;
  logic [AW-1:0]    sys_wr_addr;
  logic [BLOCK-1:0] sys_wr_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLOCK-1:0] out_data;
  logic             busy;
  logic [1:0]       status;

  modport master (
    output in_valid, in_data, go, sys_done, sys_fail, sys_success,
           sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data, out_ready,
    input  in_ready, sys_start, sys_rd_data, out_valid, out_data, busy, status
  );

  modport slave (
    input  in_valid, in_data, go, sys_done, sys_fail, sys_success,
           sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data, out_ready,
    output in_ready, sys_start, sys_rd_data, out_valid, out_data, busy, status
  );
endinterface

// File: rtl/systemizer_feeder_matrix_store.sv
// DEPTH x BLOCK flop array: one write port, one registered read port,
// one combinational read port used for drain prefetch.
module matrix_store
  import systemizer_pkg::*;
#(
  parameter int DEPTH = 24,
  parameter int BLOCK = 4,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BLOCK-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [BLOCK-1:0] rd_data,
  input  logic [AW-1:0]    pf_addr,
  output logic [BLOCK-1:0] pf_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [BLOCK-1:0] mem_q [DEPTH];
  logic [BLOCK-1:0] mem_d [DEPTH];
  logic [BLOCK-1:0] rd_data_q;
  logic [BLOCK-1:0] rd_data_d;

  logic wr_in_range;
  logic rd_in_range;
  logic pf_in_range;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
  assign pf_in_range = {1'b0, pf_addr} < DEPTH_W;

  // Read samples mem_q, so a same-address write in the same cycle returns old data.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (wr_en && wr_in_range) mem_d[wr_addr] = wr_data;
    if (rd_en) rd_data_d = rd_in_range ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
  assign pf_data = pf_in_range ? mem_q[pf_addr] : '0;

endmodule

// File: rtl/systemizer_feeder.sv
// Loads the matrix store, launches the systemizer, serves its memory ports
// during the run and drains the systematic matrix on success.
module systemizer_feeder
  import systemizer_pkg::*;
#(
  parameter int L       = 8,
  parameter int K       = 10,
  parameter int BLOCK   = 4,
  parameter int TIMEOUT = 4096
) (
  input logic           clk,
  input logic           rst,
  systemizer_feeder_if.slave bus
);

  localparam int WPR   = calc_wpr(K, BLOCK);
  localparam int DEPTH = calc_depth(L, K, BLOCK);
  localparam int AW    = calc_aw(L, K, BLOCK);
  localparam int TW    = $clog2(TIMEOUT) + 1;
  localparam int REM   = K % BLOCK;

  localparam logic [BLOCK-1:0] PAD_MASK     = (REM == 0) ? '1 : BLOCK'((1 << REM) - 1);
  localparam logic [AW-1:0]    LAST_ADDR    = AW'(DEPTH - 1);
  localparam logic [AW:0]      DEPTH_P      = (AW+1)'(DEPTH);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             sys_start_q, sys_start_d;
  logic             out_valid_q, out_valid_d;
  logic [BLOCK-1:0] out_data_q, out_data_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [BLOCK-1:0] mem_wdata;
  logic             mem_re;
  logic [BLOCK-1:0] pf_data;
  logic             last_col;
  logic             unused_fail;

  // Any done without success is a failure, so the fail flag carries no extra information.
  assign unused_fail = bus.sys_fail;
  assign last_col    = (int'(wptr_q) % WPR) == (WPR - 1);

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    tcnt_d      = tcnt_q;
    sys_start_d = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_we      = 1'b0;
    mem_waddr   = wptr_q;
    mem_wdata   = bus.in_data;
    mem_re      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        if (bus.in_valid) begin
          mem_we    = 1'b1;
          mem_wdata = last_col ? (bus.in_data & PAD_MASK) : bus.in_data;
          if (wptr_q == LAST_ADDR) begin
            wptr_d  = '0;
            state_d = S_LOADED;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      S_LOADED: begin
        if (bus.go) begin
          status_d    = STAT_NONE;
          sys_start_d = 1'b1;
          tcnt_d      = '0;
          rptr_d      = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        mem_we    = bus.sys_wr_en;
        mem_waddr = bus.sys_wr_addr;
        mem_wdata = bus.sys_wr_data;
        mem_re    = bus.sys_rd_en;
        tcnt_d    = tcnt_q + 1'b1;
        if (bus.sys_done) begin
          if (bus.sys_success) begin
            status_d = STAT_SUCCESS;
            state_d  = S_DRAIN;
          end else begin
            status_d = STAT_FAIL;
            state_d  = S_LOAD;
          end
        end else if (tcnt_q == TIMEOUT_LAST) begin
          status_d = STAT_TIMEOUT;
          state_d  = S_LOAD;
        end
      end
      S_DRAIN: begin
        // rptr is one wider than an address so it can mark "all words fetched".
        if (!out_valid_q || bus.out_ready) begin
          if (rptr_q == DEPTH_P) begin
            out_valid_d = 1'b0;
            rptr_d      = '0;
            wptr_d      = '0;
            state_d     = S_LOAD;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = pf_data;
            rptr_d      = rptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      status_q    <= STAT_NONE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      tcnt_q      <= '0;
      sys_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      tcnt_q      <= tcnt_d;
      sys_start_q <= sys_start_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  matrix_store #(
    .DEPTH (DEPTH),
    .BLOCK (BLOCK),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_en   (mem_re),
    .rd_addr (bus.sys_rd_addr),
    .rd_data (bus.sys_rd_data),
    .pf_addr (rptr_q[AW-1:0]),
    .pf_data (pf_data)
  );

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.sys_start = sys_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.status    = status_q;

endmodule

// File: tb/tb_systemizer_feeder.sv
// Randomized bench for systemizer_feeder against a word-array model of the matrix store.
module tb_systemizer_feeder;

  localparam int L       = 8;
  localparam int K       = 10;
  localparam int BLOCK   = 4;
  localparam int TIMEOUT = 16;
  localparam int WPR     = (K + BLOCK - 1) / BLOCK;
  localparam int DEPTH   = L * WPR;
  localparam int AW      = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systemizer_feeder_if #(.BLOCK(BLOCK), .AW(AW)) bus ();

  systemizer_feeder #(
    .L       (L),
    .K       (K),
    .BLOCK   (BLOCK),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [BLOCK-1:0] exp_mem [DEPTH];
  logic [BLOCK-1:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.go          = 1'b0;
    bus.sys_done    = 1'b0;
    bus.sys_fail    = 1'b0;
    bus.sys_success = 1'b0;
    bus.sys_rd_en   = 1'b0;
    bus.sys_rd_addr = '0;
    bus.sys_wr_en   = 1'b0;
    bus.sys_wr_addr = '0;
    bus.sys_wr_data = '0;
    bus.out_ready   = 1'b0;
  endtask

  // A loaded bit survives only if its column within the row is below K.
  function automatic logic [BLOCK-1:0] stored_word(input int idx, input logic [BLOCK-1:0] d);
    logic [BLOCK-1:0] r;
    r = d;
    for (int b = 0; b < BLOCK; b++)
      if ((idx % WPR) * BLOCK + b >= K) r[b] = 1'b0;
    return r;
  endfunction

  task automatic load_matrix(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      logic [BLOCK-1:0] d;
      if (mode == 1) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          tick();
        end
      end
      d = (mode == 0) ? '1 : BLOCK'($urandom);
      check("load_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      exp_mem[i] = stored_word(i, d);
    end
    bus.in_valid = 1'b0;
    check("loaded_ready", bus.in_ready, 0);
    check("loaded_busy", bus.busy, 0);
  endtask

  task automatic start_run();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("sys_start_hi", bus.sys_start, 1);
    check("run_busy", bus.busy, 1);
    check("run_status_clr", bus.status, 0);
  endtask

  task automatic sys_op(input logic re, input int ra, input logic we, input int wa,
                        input logic [BLOCK-1:0] wd, input string tag);
    bus.sys_rd_en   = re;
    bus.sys_rd_addr = AW'(ra);
    bus.sys_wr_en   = we;
    bus.sys_wr_addr = AW'(wa);
    bus.sys_wr_data = wd;
    tick();
    bus.sys_rd_en = 1'b0;
    bus.sys_wr_en = 1'b0;
    if (re) exp_rd = (ra < DEPTH) ? exp_mem[ra] : '0;
    if (we && wa < DEPTH) exp_mem[wa] = wd;
    check(tag, bus.sys_rd_data, exp_rd);
    check("sys_start_lo", bus.sys_start, 0);
  endtask

  task automatic rand_op();
    sys_op(1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
           $urandom_range(0, 31), BLOCK'($urandom), "rnd_rd");
  endtask

  task automatic finish_run(input logic s, input logic f);
    bus.sys_done    = 1'b1;
    bus.sys_success = s;
    bus.sys_fail    = f;
    tick();
    bus.sys_done    = 1'b0;
    bus.sys_success = 1'b0;
    bus.sys_fail    = 1'b0;
  endtask

  task automatic drain(input int mode);
    int idx;
    int cyc;
    logic stalled;
    logic rdy;
    logic [BLOCK-1:0] held;
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    check("drain_entry_valid", bus.out_valid, 0);
    while (idx < DEPTH && cyc < 400) begin
      if (cyc == 1) check("drain_first_valid", bus.out_valid, 1);
      if (stalled) begin
        check("drain_valid_hold", bus.out_valid, 1);
        check("drain_stable", bus.out_data, held);
      end
      if (mode == 0) rdy = (cyc < 3) ? 1'b0 : cyc[0];
      else           rdy = 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        check("drain_word", bus.out_data, exp_mem[idx]);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = bus.out_valid;
        held    = bus.out_data;
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", idx, DEPTH);
    check("drain_valid_drop", bus.out_valid, 0);
    check("drain_done_busy", bus.busy, 0);
    check("drain_done_ready", bus.in_ready, 1);
    check("drain_status_hold", bus.status, 1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_sys_start"}, bus.sys_start, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_status"}, bus.status, 0);
    check({tag, "_rd_data"}, bus.sys_rd_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    rst    = 1'b1;
    exp_rd = '0;
    tick();
    tick();
    reset_checks("rst");
    rst = 1'b0;

    // Load with padding, then inputs that must be ignored in LOADED.
    load_matrix(0);
    bus.sys_done    = 1'b1;
    bus.sys_success = 1'b1;
    bus.sys_wr_en   = 1'b1;
    bus.sys_wr_addr = '0;
    bus.sys_wr_data = 4'h5;
    bus.sys_rd_en   = 1'b1;
    bus.sys_rd_addr = '0;
    bus.in_valid    = 1'b1;
    bus.in_data     = '0;
    tick();
    idle();
    check("loaded_ign_busy", bus.busy, 0);
    check("loaded_ign_status", bus.status, 0);
    check("loaded_ign_ready", bus.in_ready, 0);
    check("loaded_ign_rd", bus.sys_rd_data, exp_rd);

    start_run();
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    bus.go       = 1'b1;
    sys_op(1'b0, 0, 1'b1, 7, 4'hA, "wr7");
    sys_op(1'b1, 7, 1'b0, 0, 4'h0, "rd7");
    sys_op(1'b1, 3, 1'b1, 3, 4'h5, "rw3_old");
    sys_op(1'b1, 3, 1'b0, 0, 4'h0, "rd3_new");
    sys_op(1'b1, 2, 1'b0, 0, 4'h0, "rd2_pad");
    sys_op(1'b1, 30, 1'b1, 29, 4'h6, "rd_oob");
    repeat (4) rand_op();
    bus.in_valid = 1'b0;
    bus.go       = 1'b0;
    finish_run(1'b1, 1'b0);
    check("succ_status", bus.status, 1);
    check("succ_busy", bus.busy, 1);
    check("succ_ready", bus.in_ready, 0);
    drain(0);

    // go in LOAD has no effect.
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    check("load_go_start", bus.sys_start, 0);
    check("load_go_busy", bus.busy, 0);
    check("load_go_ready", bus.in_ready, 1);

    // Random load, random traffic, random backpressure drain.
    load_matrix(1);
    start_run();
    repeat (8) rand_op();
    finish_run(1'b1, 1'b0);
    check("succ2_status", bus.status, 1);
    drain(1);

    // Failure flag.
    load_matrix(1);
    start_run();
    repeat (3) rand_op();
    finish_run(1'b0, 1'b1);
    check("fail_status", bus.status, 2);
    check("fail_busy", bus.busy, 0);
    check("fail_ready", bus.in_ready, 1);
    repeat (2) begin
      tick();
      check("fail_no_drain", bus.out_valid, 0);
    end

    // Timeout exactly TIMEOUT cycles after sys_start.
    load_matrix(1);
    start_run();
    repeat (TIMEOUT - 1) tick();
    check("to_busy_before", bus.busy, 1);
    check("to_status_before", bus.status, 0);
    tick();
    check("to_status", bus.status, 3);
    check("to_busy", bus.busy, 0);
    check("to_ready", bus.in_ready, 1);

    // Done with neither flag counts as failure.
    load_matrix(1);
    start_run();
    finish_run(1'b0, 1'b0);
    check("noflag_status", bus.status, 2);
    check("noflag_busy", bus.busy, 0);

    // Reset mid-run.
    load_matrix(1);
    start_run();
    repeat (3) rand_op();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd = '0;
    reset_checks("rst_run");

    // Reset mid-drain with a word pending.
    load_matrix(1);
    start_run();
    finish_run(1'b1, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", bus.out_valid, 1);
    check("pre_rst_word0", bus.out_data, exp_mem[0]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_checks("rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
